// File: rtl/scarv_cop_wb.sv
// scarv_cop_wb: COP writeback stage; queues unit results and drains them onto the single CPR write port.
// Optional same-cycle bypass of an idle stage is enabled by defining SCARV_COP_WB_BYPASS_EN.
module scarv_cop_wb #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        g_clk,
    input  logic        g_reset,
    output logic        g_clk_req,
    input  logic        cprs_init,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [3:0]  res_rd,
    input  logic [3:0]  res_wen,
    input  logic        res_wide,
    input  logic [63:0] res_data,
    output logic [3:0]  crd_wen,
    output logic [3:0]  crd_addr,
    output logic [31:0] crd_wdata,
    output logic [15:0] pend_mask,
    output logic        wb_idle
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, HI} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]         count_q;
    logic [FIFO_DEPTH-1:0] vld_q;
    logic [FIFO_DEPTH-1:0] mem_wide;
    logic [3:0]            mem_rd   [FIFO_DEPTH];
    logic [3:0]            mem_wen  [FIFO_DEPTH];
    logic [63:0]           mem_data [FIFO_DEPTH];
    logic                  empty, full, pop, push, bypass;
    logic [3:0]            h_rd, h_wen;
    logic                  h_wide;
    logic [63:0]           h_data;

    assign empty     = count_q == '0;
    assign full      = count_q == CW'(FIFO_DEPTH);
    assign h_rd      = mem_rd[rd_ptr_q];
    assign h_wen     = mem_wen[rd_ptr_q];
    assign h_wide    = mem_wide[rd_ptr_q];
    assign h_data    = mem_data[rd_ptr_q];
    assign wb_idle   = empty && state_q == IDLE;
    assign g_clk_req = res_valid || !wb_idle;

`ifdef SCARV_COP_WB_BYPASS_EN
    assign bypass    = wb_idle && !cprs_init && res_valid;
    assign res_ready = !cprs_init && (!full || pop);
    assign push      = res_valid && res_ready && !(bypass && !res_wide);
`else
    assign bypass    = 1'b0;
    assign res_ready = !cprs_init && !full;
    assign push      = res_valid && res_ready;
`endif

    // Drain the head entry (or a bypassed result) onto the write port; wide heads take two cycles.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        crd_wen   = '0;
        crd_addr  = '0;
        crd_wdata = '0;
        if (cprs_init) begin
            state_d = IDLE;
        end else if (state_q == HI) begin
            crd_wen   = h_wen;
            crd_addr  = {h_rd[3:1], 1'b1};
            crd_wdata = h_data[63:32];
            pop       = 1'b1;
            state_d   = IDLE;
        end else if (!empty) begin
            crd_wen   = h_wen;
            crd_addr  = h_wide ? {h_rd[3:1], 1'b0} : h_rd;
            crd_wdata = h_data[31:0];
            pop       = !h_wide;
            state_d   = h_wide ? HI : IDLE;
        end else if (bypass) begin
            crd_wen   = res_wen;
            crd_addr  = res_wide ? {res_rd[3:1], 1'b0} : res_rd;
            crd_wdata = res_data[31:0];
            state_d   = res_wide ? HI : IDLE;
        end
    end

    // Union of queued destinations; a head already in HI has written its low register.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (vld_q[i] && mem_wen[i] != '0) begin
                pend_mask = pend_mask | (mem_wide[i]
                    ? (((state_q == HI && PW'(i) == rd_ptr_q) ? 16'd2 : 16'd3) << {mem_rd[i][3:1], 1'b0})
                    : (16'd1 << mem_rd[i]));
            end
        end
    end

    // Pointer, occupancy and FSM state; cprs_init flushes the queue like reset.
    always_ff @(posedge g_clk) begin
        if (g_reset || cprs_init) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_q + CW'(push) - CW'(pop);
            if (pop) begin
                rd_ptr_q        <= rd_ptr_q + PW'(1);
                vld_q[rd_ptr_q] <= 1'b0;
            end
            if (push) begin
                wr_ptr_q        <= wr_ptr_q + PW'(1);
                vld_q[wr_ptr_q] <= 1'b1;
            end
        end
    end

    // Entry payload storage; slot validity is tracked separately so no reset is needed here.
    always_ff @(posedge g_clk) begin
        if (push) begin
            mem_rd[wr_ptr_q]   <= res_rd;
            mem_wen[wr_ptr_q]  <= res_wen;
            mem_wide[wr_ptr_q] <= res_wide;
            mem_data[wr_ptr_q] <= res_data;
        end
    end
endmodule
